// File: rtl/readout_v1_if.sv
// Bus between the exposure sequencer (master) and the row readout generator (slave).
// trigger_i is a one-cycle start pulse with no ready: it is taken only in IDLE with NUM_ROW != 0, and dropped otherwise.
interface readout_v1_if #(
    parameter int CNT_W = 16
);
    logic             trigger_i;
    logic [CNT_W-1:0] T1;
    logic [CNT_W-1:0] T2;
    logic [CNT_W-1:0] T3;
    logic [CNT_W-1:0] T4;
    logic [CNT_W-1:0] T5;
    logic [CNT_W-1:0] T6;
    logic [9:0]       NUM_ROW;
    logic             re_busy;
    logic [9:0]       ROWADD;
    logic             COL_L_EN;
    logic             COL_PRECH;
    logic             CP_MUX_IN;
    logic             MUX_START;
    logic             PIXRES;
    logic             PH1;
    logic             PGA_RES;
    logic             SAMP_R;
    logic             SAMP_S;
    logic             READ_R;
    logic             READ_S;

    modport master (
        output trigger_i, T1, T2, T3, T4, T5, T6, NUM_ROW,
        input  re_busy, ROWADD, COL_L_EN, COL_PRECH, CP_MUX_IN, MUX_START,
               PIXRES, PH1, PGA_RES, SAMP_R, SAMP_S, READ_R, READ_S
    );

    modport slave (
        input  trigger_i, T1, T2, T3, T4, T5, T6, NUM_ROW,
        output re_busy, ROWADD, COL_L_EN, COL_PRECH, CP_MUX_IN, MUX_START,
               PIXRES, PH1, PGA_RES, SAMP_R, SAMP_S, READ_R, READ_S
    );
endinterface

// File: rtl/readout_v1.sv
// Row-sequential readout timing generator: walks NUM_ROW rows of T1 cycles each and
// drives registered column / pixel / CDS strobes from the in-row cycle counter.
module readout_v1 #(
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          rst,
    readout_v1_if.slave   bus,
    output logic [0:0]    dbg_state
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [9:0]       row_q, row_d;
    logic [9:0]       nrow_q, nrow_d;
    logic [CNT_W-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic [CNT_W-1:0] t4_q, t4_d, t5_q, t5_d, t6_q, t6_d;
    logic [10:0]      strb_q, strb_d;

    logic [CNT_W:0]   cw, t2w, t3w, t5w, pix_end, mux_end, ph_inc;
    logic [CNT_W-1:0] cp_len;
    logic             cp_on;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        row_d   = row_q;
        nrow_d  = nrow_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        t3_d    = t3_q;
        t4_d    = t4_q;
        t5_d    = t5_q;
        t6_d    = t6_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.trigger_i && (bus.NUM_ROW != 10'd0)) begin
                    state_d = ST_READ;
                    c_d     = '0;
                    row_d   = '0;
                    nrow_d  = bus.NUM_ROW;
                    t1_d    = (bus.T1 == '0) ? CNT_W'(1) : bus.T1;
                    t2_d    = bus.T2;
                    t3_d    = bus.T3;
                    t4_d    = bus.T4;
                    t5_d    = bus.T5;
                    t6_d    = bus.T6;
                end
            end
            default: begin
                if (c_q == t1_q - CNT_W'(1)) begin
                    c_d = '0;
                    if (row_q == nrow_q - 10'd1) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 10'd1;
                    end
                end else begin
                    c_d = c_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Strobes are computed from the next-cycle counter so they register in step with c.
    always_comb begin
        cw      = {1'b0, c_d};
        t2w     = {1'b0, t2_d};
        t3w     = {1'b0, t3_d};
        t5w     = {1'b0, t5_d};
        pix_end = t2w + {1'b0, t6_d};
        mux_end = t5w + {1'b0, t4_d};
        ph_inc  = {1'b0, ph_q} + (CNT_W+1)'(1);

        // ph tracks (c - T5) mod T6 incrementally instead of dividing.
        if (c_d <= t5_d) begin
            ph_d = '0;
        end else if (ph_inc >= {1'b0, t6_d}) begin
            ph_d = '0;
        end else begin
            ph_d = ph_inc[CNT_W-1:0];
        end

        cp_len = ((t6_d >> 1) == '0) ? CNT_W'(1) : (t6_d >> 1);
        if (t6_d == '0) begin
            cp_on = (c_d == t5_d);
        end else begin
            cp_on = (c_d >= t5_d) && (ph_d < cp_len);
        end

        strb_d = '0;
        if (state_d == ST_READ) begin
            strb_d[10] = (cw < t2w);                        // COL_L_EN
            strb_d[9]  = (cw < t3w);                        // COL_PRECH
            strb_d[8]  = cp_on;                             // CP_MUX_IN
            strb_d[7]  = (cw >= t5w) && (cw < mux_end);     // MUX_START
            strb_d[6]  = (cw >= t2w) && (cw < pix_end);     // PIXRES
            strb_d[5]  = (cw >= t3w) && (cw < t2w);         // PH1
            strb_d[4]  = (cw < t3w);                        // PGA_RES
            strb_d[3]  = (cw >= pix_end);                   // SAMP_R
            strb_d[2]  = (cw >= t3w) && (cw < t2w);         // SAMP_S
            strb_d[1]  = (cw >= t2w);                       // READ_R
            strb_d[0]  = (cw >= t5w) && (cw < t2w);         // READ_S
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            ph_q    <= '0;
            row_q   <= '0;
            nrow_q  <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            t4_q    <= '0;
            t5_q    <= '0;
            t6_q    <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            ph_q    <= ph_d;
            row_q   <= row_d;
            nrow_q  <= nrow_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            t4_q    <= t4_d;
            t5_q    <= t5_d;
            t6_q    <= t6_d;
            strb_q  <= strb_d;
        end
    end

    assign dbg_state     = state_q;
    assign bus.re_busy   = (state_q == ST_READ);
    assign bus.ROWADD    = row_q;
    assign bus.COL_L_EN  = strb_q[10];
    assign bus.COL_PRECH = strb_q[9];
    assign bus.CP_MUX_IN = strb_q[8];
    assign bus.MUX_START = strb_q[7];
    assign bus.PIXRES    = strb_q[6];
    assign bus.PH1       = strb_q[5];
    assign bus.PGA_RES   = strb_q[4];
    assign bus.SAMP_R    = strb_q[3];
    assign bus.SAMP_S    = strb_q[2];
    assign bus.READ_R    = strb_q[1];
    assign bus.READ_S    = strb_q[0];
endmodule

// File: tb/tb_readout_v1.sv
// Directed bench for readout_v1: vector table of strobe snapshots plus frame-level sequences.
module tb_readout_v1;
    logic       CLK = 1'b0;
    logic       rst;
    logic [0:0] dbg_state;
    logic [10:0] strobes;

    always #5 CLK = ~CLK;

    readout_v1_if #(.CNT_W(16)) bus();
    readout_v1 #(.CNT_W(16)) dut (.CLK(CLK), .rst(rst), .bus(bus), .dbg_state(dbg_state));

    // Order: COL_L_EN COL_PRECH CP_MUX_IN MUX_START PIXRES PH1 PGA_RES SAMP_R SAMP_S READ_R READ_S
    assign strobes = {bus.COL_L_EN, bus.COL_PRECH, bus.CP_MUX_IN, bus.MUX_START, bus.PIXRES,
                      bus.PH1, bus.PGA_RES, bus.SAMP_R, bus.SAMP_S, bus.READ_R, bus.READ_S};

    typedef struct {
        logic [15:0] t1, t2, t3, t4, t5, t6;
        logic [9:0]  nrow;
        int          n;
        logic [10:0] strb;
        logic [9:0]  row;
        logic        busy;
    } vec_t;

    vec_t vecs[21];
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    endtask

    task automatic tick(input logic trig);
        @(negedge CLK);
        bus.trigger_i = trig;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_params(input logic [15:0] t1, t2, t3, t4, t5, t6, input logic [9:0] nr);
        bus.T1 = t1; bus.T2 = t2; bus.T3 = t3; bus.T4 = t4; bus.T5 = t5; bus.T6 = t6;
        bus.NUM_ROW = nr;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 2000; w++) begin
            if (!bus.re_busy) break;
            tick(1'b0);
        end
        check("idle_wait", {31'd0, bus.re_busy}, 32'd0);
    endtask

    int cyc, n_extra;
    int t_row[20];
    int l_rise, l_fall, pr_rise, pr_fall, ms_rise, ms_fall, cp1, cp2;
    logic p_l, p_pr, p_ms, p_cp;
    logic [9:0] p_row;

    initial begin
        vecs[0]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 0,  11'b11000010000, 10'd0, 1'b1};
        vecs[1]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 2,  11'b10000100100, 10'd0, 1'b1};
        vecs[2]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 5,  11'b10110100101, 10'd0, 1'b1};
        vecs[3]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 7,  11'b10000100101, 10'd0, 1'b1};
        vecs[4]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 10, 11'b00001000010, 10'd0, 1'b1};
        vecs[5]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 12, 11'b00101000010, 10'd0, 1'b1};
        vecs[6]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 19, 11'b00000001010, 10'd0, 1'b1};
        vecs[7]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 21, 11'b11000010000, 10'd1, 1'b1};
        vecs[8]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 39, 11'b00000001010, 10'd1, 1'b1};
        vecs[9]  = '{16'd20, 16'd10, 16'd2, 16'd3, 16'd4, 16'd4, 10'd2, 40, 11'b00000000000, 10'd0, 1'b0};
        vecs[10] = '{16'd0,  16'd5,  16'd2, 16'd1, 16'd0, 16'd0, 10'd3, 0,  11'b11110010001, 10'd0, 1'b1};
        vecs[11] = '{16'd0,  16'd5,  16'd2, 16'd1, 16'd0, 16'd0, 10'd3, 2,  11'b11110010001, 10'd2, 1'b1};
        vecs[12] = '{16'd0,  16'd5,  16'd2, 16'd1, 16'd0, 16'd0, 10'd3, 3,  11'b00000000000, 10'd0, 1'b0};
        vecs[13] = '{16'd8,  16'd12, 16'd3, 16'd20, 16'd6, 16'd1, 10'd1, 2, 11'b11000010000, 10'd0, 1'b1};
        vecs[14] = '{16'd8,  16'd12, 16'd3, 16'd20, 16'd6, 16'd1, 10'd1, 7, 11'b10110100101, 10'd0, 1'b1};
        vecs[15] = '{16'd8,  16'd12, 16'd3, 16'd20, 16'd6, 16'd1, 10'd1, 8, 11'b00000000000, 10'd0, 1'b0};
        vecs[16] = '{16'd10, 16'd3,  16'd5, 16'd0, 16'd9, 16'd0, 10'd1, 4,  11'b01000011010, 10'd0, 1'b1};
        vecs[17] = '{16'd10, 16'd3,  16'd5, 16'd0, 16'd9, 16'd0, 10'd1, 9,  11'b00100001010, 10'd0, 1'b1};
        vecs[18] = '{16'd20, 16'd4,  16'd1, 16'd1, 16'd3, 16'd5, 10'd1, 8,  11'b00101000010, 10'd0, 1'b1};
        vecs[19] = '{16'd20, 16'd4,  16'd1, 16'd1, 16'd3, 16'd5, 10'd1, 9,  11'b00100001010, 10'd0, 1'b1};
        vecs[20] = '{16'd20, 16'd4,  16'd1, 16'd1, 16'd3, 16'd5, 10'd1, 10, 11'b00000001010, 10'd0, 1'b1};

        // Reset held, then released with no trigger
        rst = 1'b0;
        bus.trigger_i = 1'b0;
        set_params(16'd1724, 16'd862, 16'd2, 16'd3, 16'd2, 16'd20, 10'd20);
        repeat (3) @(posedge CLK);
        #1;
        check("rst_strobes", {21'd0, strobes}, 32'd0);
        check("rst_busy", {31'd0, bus.re_busy}, 32'd0);
        @(negedge CLK);
        rst = 1'b1;
        repeat (50) tick(1'b0);
        check("idle_strobes", {21'd0, strobes}, 32'd0);
        check("idle_busy", {31'd0, bus.re_busy}, 32'd0);
        check("idle_rowadd", {22'd0, bus.ROWADD}, 32'd0);
        check("idle_state", {31'd0, dbg_state}, 32'd0);

        // Vector table: trigger, step n cycles, snapshot
        for (int i = 0; i < 21; i++) begin
            wait_idle();
            set_params(vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].t4, vecs[i].t5, vecs[i].t6, vecs[i].nrow);
            tick(1'b1);
            for (int k = 0; k < vecs[i].n; k++) tick(1'b0);
            check($sformatf("vec%0d_strobes", i), {21'd0, strobes}, {21'd0, vecs[i].strb});
            check($sformatf("vec%0d_rowadd", i), {22'd0, bus.ROWADD}, {22'd0, vecs[i].row});
            check($sformatf("vec%0d_busy", i), {31'd0, bus.re_busy}, {31'd0, vecs[i].busy});
        end

        // Default full frame
        wait_idle();
        set_params(16'd1724, 16'd862, 16'd2, 16'd3, 16'd2, 16'd20, 10'd20);
        for (int r = 0; r < 20; r++) exp_q.push_back(r);
        l_rise = -1; l_fall = -1; pr_rise = -1; pr_fall = -1;
        ms_rise = -1; ms_fall = -1; cp1 = -1; cp2 = -1; n_extra = 0;
        p_l = 1'b0; p_pr = 1'b0; p_ms = 1'b0; p_cp = 1'b0; p_row = '0;
        tick(1'b1);
        cyc = 0;
        while (bus.re_busy && cyc < 40000) begin
            if (cyc == 0 || bus.ROWADD != p_row) begin
                t_row[bus.ROWADD % 20] = cyc;
                if (exp_q.size() > 0) check("row_seq", {22'd0, bus.ROWADD}, exp_q.pop_front());
                else n_extra++;
            end
            if (bus.COL_L_EN && !p_l && l_rise < 0) l_rise = cyc;
            if (!bus.COL_L_EN && p_l && l_fall < 0) l_fall = cyc;
            if (bus.COL_PRECH && !p_pr && pr_rise < 0) pr_rise = cyc;
            if (!bus.COL_PRECH && p_pr && pr_fall < 0) pr_fall = cyc;
            if (bus.MUX_START && !p_ms && ms_rise < 0) ms_rise = cyc;
            if (!bus.MUX_START && p_ms && ms_fall < 0) ms_fall = cyc;
            if (bus.CP_MUX_IN && !p_cp) begin
                if (cp1 < 0) cp1 = cyc;
                else if (cp2 < 0) cp2 = cyc;
            end
            p_l = bus.COL_L_EN; p_pr = bus.COL_PRECH; p_ms = bus.MUX_START;
            p_cp = bus.CP_MUX_IN; p_row = bus.ROWADD;
            tick(1'b0);
            cyc++;
        end
        check("frame_len", cyc, 34480);
        check("row_seq_left", exp_q.size(), 0);
        check("row_seq_extra", n_extra, 0);
        check("row1_to_row2", t_row[2] - t_row[1], 1724);
        check("row2_to_row3", t_row[3] - t_row[2], 1724);
        check("end_rowadd", {22'd0, bus.ROWADD}, 32'd0);
        check("end_strobes", {21'd0, strobes}, 32'd0);
        check("prech_rise_at_trigger", pr_rise, 0);
        check("col_l_en_width", l_fall - l_rise, 862);
        check("col_prech_width", pr_fall - pr_rise, 2);
        check("mux_start_width", ms_fall - ms_rise, 3);
        check("cp_first_offset", cp1 - pr_rise, 2);
        check("cp_period", cp2 - cp1, 20);

        // Triggers during a frame, on its last cycle, and on the first idle cycle
        wait_idle();
        set_params(16'd50, 16'd20, 16'd2, 16'd3, 16'd2, 16'd10, 10'd4);
        tick(1'b1);
        cyc = 0;
        while (bus.re_busy && cyc < 1000) begin
            tick((cyc % 10 == 5) || (cyc == 199));
            cyc++;
        end
        check("retrig_frame_len", cyc, 200);
        check("last_cycle_trig_ignored", {31'd0, bus.re_busy}, 32'd0);
        tick(1'b1);
        check("first_idle_trig_busy", {31'd0, bus.re_busy}, 32'd1);
        check("first_idle_trig_row", {22'd0, bus.ROWADD}, 32'd0);
        tick(1'b0);
        wait_idle();

        // NUM_ROW = 0 ignores the trigger
        set_params(16'd50, 16'd20, 16'd2, 16'd3, 16'd2, 16'd10, 10'd0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("nrow0_busy", {31'd0, bus.re_busy}, 32'd0);
        check("nrow0_state", {31'd0, dbg_state}, 32'd0);

        // Asynchronous reset in row 5, then a clean restart
        set_params(16'd30, 16'd10, 16'd2, 16'd3, 16'd2, 16'd4, 10'd8);
        tick(1'b1);
        for (int k = 0; k < 160; k++) tick(1'b0);
        check("pre_rst_row", {22'd0, bus.ROWADD}, 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, bus.re_busy}, 32'd0);
        check("async_rst_row", {22'd0, bus.ROWADD}, 32'd0);
        check("async_rst_strobes", {21'd0, strobes}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        rst = 1'b1;
        tick(1'b1);
        check("restart_row", {22'd0, bus.ROWADD}, 32'd0);
        check("restart_strobes", {21'd0, strobes}, 32'b11000010000);
        for (int k = 0; k < 29; k++) tick(1'b0);
        check("restart_row0_end", {22'd0, bus.ROWADD}, 32'd0);
        tick(1'b0);
        check("restart_row1", {22'd0, bus.ROWADD}, 32'd1);
        cyc = 30;
        while (bus.re_busy && cyc < 1000) begin
            tick(1'b0);
            cyc++;
        end
        check("restart_frame_len", cyc, 240);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
